// File: rtl/ball_pkg.sv
// Shared types and constants for the ball hit manager: ball tree indexing,
// size classes and the controller state encoding.
package ball_pkg;

  localparam int NUM_BALLS  = 15;
  localparam int IDX_HUGE   = 0;
  localparam int IDX_BIG0   = 1;
  localparam int IDX_MED0   = 3;
  localparam int IDX_SMALL0 = 7;

  typedef enum logic [1:0] {
    SZ_HUGE,
    SZ_BIG,
    SZ_MED,
    SZ_SMALL
  } size_class_t;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    EVAL,
    CLEAR,
    OVER
  } state_t;

  // Balls form a binary heap: children of idx live at 2*idx+1 and 2*idx+2.
  function automatic logic [3:0] child_base(input logic [3:0] idx);
    return 4'(2 * int'(idx) + 1);
  endfunction

  function automatic size_class_t size_of(input logic [3:0] idx);
    if (int'(idx) < IDX_BIG0)        return SZ_HUGE;
    else if (int'(idx) < IDX_MED0)   return SZ_BIG;
    else if (int'(idx) < IDX_SMALL0) return SZ_MED;
    else                             return SZ_SMALL;
  endfunction

endpackage

// File: rtl/lowest_set_idx15.sv
// Combinational priority encoder: index of the lowest set bit of a 15-bit vector.
module lowest_set_idx15 (
  input  logic [14:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = 14; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/ball_hit_manager.sv
// Turns per-pixel ball collision flags into once-per-frame game events:
// ball pops and splits, rope retract, player lives/invulnerability, score.
//
// state | meaning
// IDLE  | after reset, waiting for the first newLevel
// PLAY  | accumulating collisions for the current frame
// EVAL  | one cycle: apply rope pop and player hit for the frame just ended
// CLEAR | every ball popped, waiting for newLevel
// OVER  | no lives left, collisions ignored until newLevel
module ball_hit_manager
  import ball_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int SCORE_W       = 16,
  parameter int PTS_HUGE      = 10,
  parameter int PTS_BIG       = 20,
  parameter int PTS_MED       = 40,
  parameter int PTS_SMALL     = 80
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               newLevel,
  input  logic [14:0]        col_player,
  input  logic [14:0]        col_rope,
  output logic [14:0]        alive,
  output logic [14:0]        spawn,
  output logic               ropeRetract,
  output logic               playerHit,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               levelClear,
  output logic               gameOver
);

  localparam int INV_W = $clog2(INVULN_FRAMES + 1);
  localparam logic [INV_W-1:0] INVULN_LOAD = INV_W'(INVULN_FRAMES);
  localparam logic [1:0]       LIVES_LOAD  = 2'(LIVES_INIT);

  state_t             state, stateNext;
  logic [14:0]        ropeAcc, ropeAccNext;
  logic               plyAcc, plyAccNext;
  logic [14:0]        ropePend, ropePendNext;
  logic               plyPend, plyPendNext;
  logic [INV_W-1:0]   invuln, invulnNext;
  logic [14:0]        aliveNext, spawnNext;
  logic               ropeRetractNext, playerHitNext;
  logic [1:0]         livesNext;
  logic [SCORE_W-1:0] scoreNext;

  logic [3:0]         victim;
  logic               victimValid;
  logic [14:0]        victimMask, childMask;
  logic [SCORE_W-1:0] popPts;
  logic [SCORE_W:0]   scoreSum;

  lowest_set_idx15 uVictim (
    .vec   (ropeAcc),
    .idx   (victim),
    .valid (victimValid)
  );

  function automatic logic [SCORE_W-1:0] pointsFor(input size_class_t sz);
    case (sz)
      SZ_HUGE: return SCORE_W'(PTS_HUGE);
      SZ_BIG:  return SCORE_W'(PTS_BIG);
      SZ_MED:  return SCORE_W'(PTS_MED);
      default: return SCORE_W'(PTS_SMALL);
    endcase
  endfunction

  always_comb begin
    victimMask = 15'(1) << victim;
    childMask  = (int'(victim) < IDX_SMALL0) ? (15'b11 << child_base(victim)) : '0;
    popPts     = pointsFor(size_of(victim));
    scoreSum   = {1'b0, score} + {1'b0, popPts};
  end

  always_comb begin
    stateNext       = state;
    aliveNext       = alive;
    spawnNext       = '0;
    ropeRetractNext = 1'b0;
    playerHitNext   = 1'b0;
    livesNext       = lives;
    scoreNext       = score;
    invulnNext      = invuln;
    ropeAccNext     = ropeAcc;
    plyAccNext      = plyAcc;
    ropePendNext    = ropePend;
    plyPendNext     = plyPend;

    if (newLevel) begin
      aliveNext    = 15'b1;
      spawnNext    = 15'b1;
      ropeAccNext  = '0;
      plyAccNext   = 1'b0;
      ropePendNext = '0;
      plyPendNext  = 1'b0;
      invulnNext   = INVULN_LOAD;
      stateNext    = PLAY;
      if (state == IDLE || state == OVER) begin
        livesNext = LIVES_LOAD;
        scoreNext = '0;
      end
    end else begin
      case (state)
        PLAY: begin
          // Flags seen on the frame boundary belong to the next frame.
          if (startOfFrame) begin
            ropePendNext = col_rope & alive;
            plyPendNext  = |(col_player & alive);
            stateNext    = EVAL;
          end else begin
            ropeAccNext = ropeAcc | (col_rope & alive);
            plyAccNext  = plyAcc | (|(col_player & alive));
          end
        end
        EVAL: begin
          if (victimValid) begin
            aliveNext       = (alive & ~victimMask) | childMask;
            spawnNext       = childMask;
            scoreNext       = scoreSum[SCORE_W] ? '1 : scoreSum[SCORE_W-1:0];
            ropeRetractNext = 1'b1;
          end
          if (plyAcc && invuln == '0 && lives != 2'd0) begin
            livesNext     = lives - 2'd1;
            playerHitNext = 1'b1;
            invulnNext    = INVULN_LOAD;
          end else if (invuln != '0) begin
            invulnNext = invuln - 1'b1;
          end
          ropeAccNext  = ropePend & aliveNext;
          plyAccNext   = plyPend;
          ropePendNext = '0;
          plyPendNext  = 1'b0;
          if (livesNext == 2'd0)      stateNext = OVER;
          else if (aliveNext == '0)   stateNext = CLEAR;
          else                        stateNext = PLAY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      alive       <= '0;
      spawn       <= '0;
      ropeRetract <= 1'b0;
      playerHit   <= 1'b0;
      lives       <= '0;
      score       <= '0;
      invuln      <= '0;
      ropeAcc     <= '0;
      plyAcc      <= 1'b0;
      ropePend    <= '0;
      plyPend     <= 1'b0;
    end else begin
      state       <= stateNext;
      alive       <= aliveNext;
      spawn       <= spawnNext;
      ropeRetract <= ropeRetractNext;
      playerHit   <= playerHitNext;
      lives       <= livesNext;
      score       <= scoreNext;
      invuln      <= invulnNext;
      ropeAcc     <= ropeAccNext;
      plyAcc      <= plyAccNext;
      ropePend    <= ropePendNext;
      plyPend     <= plyPendNext;
    end
  end

  assign levelClear = (state == CLEAR);
  assign gameOver   = (state == OVER);

endmodule

// File: tb/tb_ball_hit_manager.sv
// Directed bench for ball_hit_manager: level start, pops and splits,
// invulnerability window, level clear, game over and reset mid-frame.
module tb_ball_hit_manager;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        newLevel = 1'b0;
  logic [14:0] col_player = '0;
  logic [14:0] col_rope = '0;
  logic [14:0] alive, spawn;
  logic        ropeRetract, playerHit, levelClear, gameOver;
  logic [1:0]  lives;
  logic [15:0] score;

  int nChecks = 0;
  int nPass   = 0;

  ball_hit_manager dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .newLevel     (newLevel),
    .col_player   (col_player),
    .col_rope     (col_rope),
    .alive        (alive),
    .spawn        (spawn),
    .ropeRetract  (ropeRetract),
    .playerHit    (playerHit),
    .lives        (lives),
    .score        (score),
    .levelClear   (levelClear),
    .gameOver     (gameOver)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulseNewLevel();
    newLevel = 1'b1;
    tick(1);
    newLevel = 1'b0;
  endtask

  // Collisions for cyc cycles, then a frame boundary (with optional flags on it)
  // and the EVAL cycle; returns sampled just after the EVAL edge.
  task automatic frame(input logic [14:0] rope, input logic [14:0] ply, input int cyc,
                       input logic [14:0] sofRope);
    col_rope   = rope;
    col_player = ply;
    if (cyc > 0) tick(cyc);
    col_rope     = sofRope;
    col_player   = '0;
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    col_rope     = '0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [14:0] expAlive [12] = '{15'h01F0, 15'h07E0, 15'h1FC0, 15'h7F80, 15'h7F00, 15'h7E00,
                                 15'h7C00, 15'h7800, 15'h7000, 15'h6000, 15'h4000, 15'h0000};
  int          expScore [12] = '{90, 130, 170, 210, 290, 370, 450, 530, 610, 690, 770, 850};
  int          hitFrames[$];

  initial begin
    #2 reset = 1'b1;
    tick(2);
    chk("rst_alive", 32'(alive), 32'h0);
    chk("rst_lives", 32'(lives), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_flags", {30'd0, levelClear, gameOver}, 32'd0);
    reset = 1'b0;
    tick(1);

    pulseNewLevel();
    chk("nl_alive", 32'(alive), 32'h1);
    chk("nl_spawn", 32'(spawn), 32'h1);
    chk("nl_lives", 32'(lives), 32'd3);
    chk("nl_score", 32'(score), 32'd0);
    tick(1);
    chk("nl_spawn_clr", 32'(spawn), 32'h0);

    frame(15'h0001, 15'h0, 3, 15'h0);
    chk("pop0_alive", 32'(alive), 32'h6);
    chk("pop0_spawn", 32'(spawn), 32'h6);
    chk("pop0_retract", 32'(ropeRetract), 32'd1);
    chk("pop0_score", 32'(score), 32'd10);
    tick(1);
    chk("pop0_retract_clr", 32'(ropeRetract), 32'd0);

    frame(15'h0006, 15'h0, 2, 15'h0);
    chk("pop1_alive", 32'(alive), 32'h1C);
    chk("pop1_spawn", 32'(spawn), 32'h18);
    chk("pop1_score", 32'(score), 32'd30);

    frame(15'h0, 15'h0004, 1, 15'h0);
    chk("invuln_nohit", 32'(playerHit), 32'd0);
    chk("invuln_lives", 32'(lives), 32'd3);
    for (int i = 0; i < 56; i++) frame(15'h0, 15'h0, 1, 15'h0);
    frame(15'h0, 15'h0004, 1, 15'h0);
    chk("invuln_last_nohit", 32'(playerHit), 32'd0);
    frame(15'h0, 15'h0004, 1, 15'h0);
    chk("hit1_pulse", 32'(playerHit), 32'd1);
    chk("hit1_lives", 32'(lives), 32'd2);

    frame(15'h0, 15'h0, 1, 15'h0004);
    chk("sof_flag_defer", 32'(ropeRetract), 32'd0);
    chk("sof_flag_alive", 32'(alive), 32'h1C);
    frame(15'h0, 15'h0, 1, 15'h0);
    chk("sof_flag_pop_alive", 32'(alive), 32'h78);
    chk("sof_flag_pop_score", 32'(score), 32'd50);
    chk("mid_clear_flag", 32'(levelClear), 32'd0);

    for (int i = 0; i < 12; i++) begin
      frame(15'h7FFF, 15'h0, 1, 15'h0);
      chk($sformatf("seq_alive%0d", i), 32'(alive), 32'(expAlive[i]));
      chk($sformatf("seq_score%0d", i), 32'(score), 32'(expScore[i]));
    end
    chk("small_no_spawn", 32'(spawn), 32'h0);
    chk("level_clear", 32'(levelClear), 32'd1);

    pulseNewLevel();
    chk("nl2_alive", 32'(alive), 32'h1);
    chk("nl2_score_kept", 32'(score), 32'd850);
    chk("nl2_lives_kept", 32'(lives), 32'd2);
    chk("nl2_clear_low", 32'(levelClear), 32'd0);

    for (int f = 1; f <= 130; f++) begin
      frame(15'h0, 15'h0001, 1, 15'h0);
      if (playerHit) hitFrames.push_back(f);
      if (gameOver) break;
    end
    chk("go_hits", 32'(hitFrames.size()), 32'd2);
    if (hitFrames.size() == 2) begin
      chk("go_hit_a", 32'(hitFrames[0]), 32'd61);
      chk("go_hit_b", 32'(hitFrames[1]), 32'd122);
    end
    chk("go_flag", 32'(gameOver), 32'd1);
    chk("go_lives", 32'(lives), 32'd0);
    frame(15'h0001, 15'h0001, 2, 15'h0);
    chk("go_ignore_rope", 32'(ropeRetract), 32'd0);
    chk("go_ignore_score", 32'(score), 32'd850);
    chk("go_ignore_hit", 32'(playerHit), 32'd0);

    pulseNewLevel();
    chk("ng_lives", 32'(lives), 32'd3);
    chk("ng_score", 32'(score), 32'd0);
    chk("ng_over_low", 32'(gameOver), 32'd0);

    col_rope = 15'h0001;
    tick(2);
    col_rope     = '0;
    newLevel     = 1'b1;
    startOfFrame = 1'b1;
    tick(1);
    newLevel     = 1'b0;
    startOfFrame = 1'b0;
    chk("nl_sof_alive", 32'(alive), 32'h1);
    chk("nl_sof_retract", 32'(ropeRetract), 32'd0);
    tick(1);
    chk("nl_sof_skip_eval", 32'(ropeRetract), 32'd0);
    chk("nl_sof_score", 32'(score), 32'd0);

    col_rope = 15'h0001;
    tick(2);
    col_rope     = '0;
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_eval_alive", 32'(alive), 32'h0);
    chk("rst_eval_pulses", {29'd0, ropeRetract, playerHit, |spawn}, 32'd0);
    chk("rst_eval_score_lives", {14'd0, lives, score}, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("post_rst_pulses", {29'd0, ropeRetract, playerHit, |spawn}, 32'd0);
    chk("post_rst_alive", 32'(alive), 32'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
